module_clkdiv_multi: RTL and testbench

MODULE_CLKDIV_MULTI -- requirements
Module: module_clkdiv_multi

---
 rtl/clkdiv_pkg.sv | 11 +
 rtl/module_clkdiv_multi_ch.sv | 77 +++++++
 rtl/module_clkdiv_multi.sv | 83 ++++++++
 tb/tb_module_clkdiv_multi.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the multi-channel clock divider.
package clkdiv_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  localparam int unsigned CNT_W_DEF = 24;

endpackage

// File: rtl/module_clkdiv_multi_ch.sv
// One divider channel: counter, divisor, mode and terminal-edge application
// of a pending configuration.
module module_clkdiv_ch
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DEF_DIV = 13500
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             pend_i,
  input  logic [CNT_W-1:0] pend_div_i,
  input  logic             pend_mode_i,
  output logic             apply_o,
  output logic             clk_div_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] last_cnt;
  mode_e            mode_q, mode_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             term;

  // Divisor 0 behaves as 1; >= keeps a held count above a smaller new divisor from running away.
  assign last_cnt = (div_q == '0) ? '0 : div_q - CNT_W'(1);
  assign term     = en_i && (cnt_q >= last_cnt);
  assign apply_o  = pend_i && (sync_i || !en_i || term);

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    mode_d = mode_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    if (sync_i) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (term) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      clk_d  = (mode_q == MODE_PULSE) ? 1'b1 : ~clk_q;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (mode_q == MODE_PULSE) clk_d = 1'b0;
    end
    if (apply_o) begin
      div_d  = pend_div_i;
      mode_d = mode_e'(pend_mode_i);
      if (!sync_i && mode_q == MODE_TOGGLE && pend_mode_i) clk_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      div_q  <= CNT_W'(DEF_DIV);
      mode_q <= MODE_TOGGLE;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      mode_q <= mode_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_div_o = clk_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/module_clkdiv_multi.sv
// Multi-channel clock divider: one shared pending-configuration slot fanned
// out to NUM_CH independent divider channels.
module module_clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter  int unsigned NUM_CH  = 4,
  parameter  int unsigned CNT_W   = CNT_W_DEF,
  parameter  int unsigned DEF_DIV = 13500,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  output logic [NUM_CH-1:0] clk_div,
  output logic [NUM_CH-1:0] tick
);

  logic             pend_valid_q, pend_valid_d;
  logic [CH_W-1:0]  pend_ch_q, pend_ch_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_mode_q, pend_mode_d;
  logic [NUM_CH-1:0] apply_w;
  logic             accept;
  logic             in_range;

  assign cfg_ready = ~pend_valid_q;
  assign accept    = cfg_valid && cfg_ready;
  assign in_range  = 32'(cfg_ch) < NUM_CH;

  // Out-of-range requests are accepted and dropped, so ready never falls for them.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_ch_d    = pend_ch_q;
    pend_div_d   = pend_div_q;
    pend_mode_d  = pend_mode_q;
    if (|apply_w) pend_valid_d = 1'b0;
    if (accept && in_range) begin
      pend_valid_d = 1'b1;
      pend_ch_d    = cfg_ch;
      pend_div_d   = cfg_div;
      pend_mode_d  = cfg_mode;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid_q <= 1'b0;
      pend_ch_q    <= '0;
      pend_div_q   <= '0;
      pend_mode_q  <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_ch_q    <= pend_ch_d;
      pend_div_q   <= pend_div_d;
      pend_mode_q  <= pend_mode_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    module_clkdiv_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk_i       (clk),
      .rst_ni      (rst),
      .en_i        (en),
      .sync_i      (sync),
      .pend_i      (pend_valid_q && (32'(pend_ch_q) == i)),
      .pend_div_i  (pend_div_q),
      .pend_mode_i (pend_mode_q),
      .apply_o     (apply_w[i]),
      .clk_div_o   (clk_div[i]),
      .tick_o      (tick[i])
    );
  end

endmodule

// File: tb/tb_module_clkdiv_multi.sv
// Bench for module_clkdiv_multi: constant vector table, directed corner
// sequences and randomized traffic against a behavioural reference model.
module tb_module_clkdiv_multi;

  localparam int NCH = 3;
  localparam int DEFD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, sync = 1'b0, cfg_valid = 1'b0, cfg_mode = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  logic [2:0] clk_div, tick;

  int checks = 0;
  int errors = 0;

  module_clkdiv_multi #(
    .NUM_CH  (NCH),
    .CNT_W   (8),
    .DEF_DIV (DEFD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_mode  (cfg_mode),
    .clk_div   (clk_div),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  // Reference model: each channel is a position within a period of D cycles.
  int m_pos[NCH];
  int m_div[NCH];
  bit m_pulse[NCH];
  bit m_out[NCH];
  bit m_tick[NCH];
  bit m_pend;
  int m_pch, m_pdiv;
  bit m_pmode;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_pos[c] = 0; m_div[c] = DEFD; m_pulse[c] = 0; m_out[c] = 0; m_tick[c] = 0;
    end
    m_pend = 0; m_pch = 0; m_pdiv = 0; m_pmode = 0;
  endtask

  task automatic model_edge();
    bit acc, done;
    int period;
    acc  = cfg_valid && !m_pend;
    done = 0;
    for (int c = 0; c < NCH; c++) begin
      bit wrap, hit, was_pulse;
      period    = (m_div[c] < 1) ? 1 : m_div[c];
      wrap      = en && (m_pos[c] + 1 >= period);
      hit       = m_pend && (m_pch == c) && (sync || !en || wrap);
      was_pulse = m_pulse[c];
      m_tick[c] = 0;
      if (sync) begin
        m_pos[c] = 0; m_out[c] = 0;
      end else if (en) begin
        m_pos[c]  = wrap ? 0 : m_pos[c] + 1;
        m_tick[c] = wrap;
        if (m_pulse[c]) m_out[c] = wrap;
        else if (wrap) m_out[c] = !m_out[c];
      end
      if (hit) begin
        m_div[c] = m_pdiv; m_pulse[c] = m_pmode; done = 1;
        if (!sync && !was_pulse && m_pmode) m_out[c] = 0;
      end
    end
    if (done) m_pend = 0;
    if (acc && int'(cfg_ch) < NCH) begin
      m_pend = 1; m_pch = int'(cfg_ch); m_pdiv = int'(cfg_div); m_pmode = cfg_mode;
    end
  endtask

  function automatic logic [6:0] model_vec();
    logic [6:0] v;
    for (int c = 0; c < NCH; c++) begin
      v[c]     = m_out[c];
      v[c + 3] = m_tick[c];
    end
    v[6] = !m_pend;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model, then sample the DUT 1 ns after the edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("model", 32'({cfg_ready, tick, clk_div}), 32'(model_vec()));
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!cfg_ready && n < 50) begin
      step();
      n++;
    end
    if (!cfg_ready) check(name, 32'(cfg_ready), 32'd1);
  endtask

  task automatic send_cfg(input logic [1:0] ch, input logic [7:0] dv, input logic md);
    cfg_ch = ch; cfg_div = dv; cfg_mode = md; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  typedef struct {
    logic       en;
    logic       sync;
    logic [2:0] exp_clk;
    logic [2:0] exp_tick;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lows;
    int highs;
    vecs = '{
      '{1, 0, 3'b000, 3'b000}, '{1, 0, 3'b000, 3'b000}, '{1, 0, 3'b000, 3'b000},
      '{1, 0, 3'b111, 3'b111}, '{1, 0, 3'b111, 3'b000}, '{1, 0, 3'b111, 3'b000},
      '{1, 0, 3'b111, 3'b000}, '{1, 0, 3'b000, 3'b111}, '{1, 0, 3'b000, 3'b000},
      '{1, 0, 3'b000, 3'b000},
      '{0, 0, 3'b000, 3'b000}, '{0, 0, 3'b000, 3'b000}, '{0, 0, 3'b000, 3'b000},
      '{0, 0, 3'b000, 3'b000}, '{0, 0, 3'b000, 3'b000},
      '{1, 0, 3'b000, 3'b000}, '{1, 0, 3'b111, 3'b111}, '{1, 0, 3'b111, 3'b000},
      '{1, 1, 3'b000, 3'b000},
      '{1, 0, 3'b000, 3'b000}, '{1, 0, 3'b000, 3'b000}, '{1, 0, 3'b000, 3'b000},
      '{1, 0, 3'b111, 3'b111}
    };

    model_reset();
    #12;
    check("reset_clk", 32'(clk_div), 32'd0);
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_ready", 32'(cfg_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;

    // Default divisor, en freeze, sync realignment.
    foreach (vecs[k]) begin
      en = vecs[k].en; sync = vecs[k].sync;
      step();
      check($sformatf("vec%0d_clk", k), 32'(clk_div), 32'(vecs[k].exp_clk));
      check($sformatf("vec%0d_tick", k), 32'(tick), 32'(vecs[k].exp_tick));
    end
    sync = 1'b0;

    // Glitch-free divisor update on ch1.
    send_cfg(2'd1, 8'd2, 1'b0);
    check("upd_ready_low", 32'(cfg_ready), 32'd0);
    lows = 1;
    while (!cfg_ready && lows < 20) begin
      step();
      if (!cfg_ready) lows++;
    end
    check("upd_ready_cycles", 32'(lows), 32'd3);
    check("upd_old_term", 32'(tick[1]), 32'd1);
    step();
    check("upd_mid", 32'(tick[1]), 32'd0);
    step();
    check("upd_new_term", 32'(tick[1]), 32'd1);

    // PULSE mode, then divisor 0 on ch2.
    send_cfg(2'd2, 8'd3, 1'b1);
    wait_ready("pulse_apply_timeout");
    check("pulse_apply_low", 32'(clk_div[2]), 32'd0);
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      highs += int'(clk_div[2]);
    end
    check("pulse_highs", 32'(highs), 32'd2);
    send_cfg(2'd2, 8'd0, 1'b1);
    wait_ready("div0_apply_timeout");
    highs = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      highs += int'(clk_div[2]);
    end
    check("div0_const_high", 32'(highs), 32'd5);

    // Out-of-range channel.
    send_cfg(2'd3, 8'd5, 1'b1);
    check("oor_ready", 32'(cfg_ready), 32'd1);
    repeat (4) step();

    // Reset with a configuration pending.
    send_cfg(2'd0, 8'd7, 1'b0);
    check("rstp_ready_low", 32'(cfg_ready), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("rstp_async_clk", 32'(clk_div), 32'd0);
    check("rstp_async_ready", 32'(cfg_ready), 32'd1);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) step();
    check("rstp_no_tick", 32'(tick[0]), 32'd0);
    step();
    check("rstp_def_div", 32'(tick[0]), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(0, 99) < 85);
      sync      = ($urandom_range(0, 99) < 3);
      cfg_valid = ($urandom_range(0, 99) < 30);
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_div   = 8'($urandom_range(0, 6));
      cfg_mode  = 1'($urandom_range(0, 1));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
